// File: rtl/avgmax_unit.sv
// avgmax_unit: reads NUM_WORDS results back from the SRAM result buffer and
// computes their maximum and truncated average. It then shifts the value
// chosen by P_s out on P_out, MSB first, and pulses done.
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous reset, active-low
//   avgmax_en  start pulse, sampled only while idle
//   P_s        serial select, latched at start (0 = max, 1 = average)
//   ry         SRAM ready; read_data is valid while high
//   read_data  SRAM read data; only the low RES_W bits are used
//   cs_n       SRAM chip select, active-low
//   we_n       SRAM write enable, active-low, tied inactive
//   address    SRAM address (BASE_ADDR + word index, wraps)
//   P_out      serial result bit
//   P_valid    high while P_out carries a valid bit
//   max_val    parallel maximum, held until the next calculation
//   avg_val    parallel average, held until the next calculation
//   busy       high whenever the unit is not idle
//   done       one-cycle pulse at the end of an operation
module avgmax_unit #(
    parameter int NUM_WORDS = 16,
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0,
    parameter int RES_W     = 17,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              avgmax_en,
    input  logic              P_s,
    input  logic              ry,
    input  logic [DATA_W-1:0] read_data,
    output logic              cs_n,
    output logic              we_n,
    output logic [ADDR_W-1:0] address,
    output logic              P_out,
    output logic              P_valid,
    output logic [RES_W-1:0]  max_val,
    output logic [RES_W-1:0]  avg_val,
    output logic              busy,
    output logic              done
);

    localparam int LOG2  = $clog2(NUM_WORDS);
    localparam int IDX_W = LOG2;
    localparam int SUM_W = RES_W + LOG2;
    localparam int CNT_W = $clog2(RES_W);

    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(RES_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_ACC,
        S_CALC,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             state_q;
    logic               ps_q;
    logic [SUM_W-1:0]   sum_q;
    logic [RES_W-1:0]   max_q;
    logic [RES_W-1:0]   r_q;
    logic [IDX_W-1:0]   idx_q;
    logic [IDX_W-1:0]   idx_inc;
    logic [RES_W-1:0]   shreg_q;
    logic [CNT_W-1:0]   bit_cnt_q;
    logic [RES_W-1:0]   avg_calc;
    logic [RES_W-1:0]   sel;

    // This block never writes the buffer.
    assign we_n = 1'b1;

    // Upper data bits carry nothing for this block.
    generate
        if (DATA_W > RES_W) begin : g_unused
            logic unused_upper;
            assign unused_upper = ^read_data[DATA_W-1:RES_W];
        end
    endgenerate

    always_comb begin
        idx_inc  = idx_q + IDX_W'(1);
        // Dropping the low LOG2 bits is the truncating divide by NUM_WORDS.
        avg_calc = sum_q[SUM_W-1:LOG2];
        sel      = ps_q ? avg_calc : max_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cs_n      <= 1'b1;
            address   <= BASE;
            P_out     <= 1'b0;
            P_valid   <= 1'b0;
            max_val   <= '0;
            avg_val   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            ps_q      <= 1'b0;
            sum_q     <= '0;
            max_q     <= '0;
            r_q       <= '0;
            idx_q     <= '0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (avgmax_en) begin
                        ps_q    <= P_s;
                        sum_q   <= '0;
                        max_q   <= '0;
                        idx_q   <= '0;
                        address <= BASE;
                        cs_n    <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= S_REQ;
                    end
                end
                S_REQ: begin
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // No timeout: the SRAM is trusted to answer eventually.
                    if (ry) begin
                        r_q     <= read_data[RES_W-1:0];
                        cs_n    <= 1'b1;
                        state_q <= S_ACC;
                    end
                end
                S_ACC: begin
                    sum_q <= sum_q + SUM_W'(r_q);
                    // Strict compare: ties keep the earlier value.
                    if (r_q > max_q) begin
                        max_q <= r_q;
                    end
                    if (idx_q == LAST_IDX) begin
                        state_q <= S_CALC;
                    end else begin
                        idx_q   <= idx_inc;
                        address <= BASE + ADDR_W'(idx_inc);
                        cs_n    <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_CALC: begin
                    max_val   <= max_q;
                    avg_val   <= avg_calc;
                    // MSB goes out immediately; the register then feeds the
                    // remaining bits from position RES_W-2 as it shifts left.
                    shreg_q   <= sel;
                    P_out     <= sel[RES_W-1];
                    P_valid   <= 1'b1;
                    bit_cnt_q <= LAST_BIT;
                    state_q   <= S_SHIFT;
                end
                S_SHIFT: begin
                    if (bit_cnt_q == '0) begin
                        P_out   <= 1'b0;
                        P_valid <= 1'b0;
                        done    <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        bit_cnt_q <= bit_cnt_q - CNT_W'(1);
                        P_out     <= shreg_q[RES_W-2];
                        shreg_q   <= shreg_q << 1;
                    end
                end
                S_DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/avgmax_unit.md
Name: avgmax_unit

Overview:
- Downstream consumer of the SRAM result buffer: after the write-back stage has stored the MAC results, this block reads NUM_WORDS words back through the SRAM wrapper port.
- It computes the maximum and the truncated average of the results.
- It then emits the value selected by P_s serially on P_out, MSB first, and pulses done.
- Parallel copies of both results stay available for debug.

Parameters:
NUM_WORDS  16  results to read; power of two, 2..256
ADDR_W  8  SRAM address width
BASE_ADDR  0  first SRAM address read
RES_W  17  result width, taken from read_data[RES_W-1:0], unsigned
DATA_W  32  SRAM data width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
avgmax_en  in  1  start pulse, sampled only in IDLE
P_s  in  1  serial select, latched at start: 0 = max, 1 = average
ry  in  1  SRAM ready; read_data valid while high
read_data  in  DATA_W  SRAM read data
cs_n  out  1  SRAM chip select, active-low
we_n  out  1  SRAM write enable, active-low; this block always drives 1
address  out  ADDR_W  SRAM address
P_out  out  1  serial result bit
P_valid  out  1  high while P_out carries a valid bit
max_val  out  RES_W  parallel maximum
avg_val  out  RES_W  parallel average
busy  out  1  high in any state other than IDLE
done  out  1  one-cycle pulse at end of operation

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; cs_n=1; we_n=1; address=BASE_ADDR; P_out=0; P_valid=0; max_val=0; avg_val=0; busy=0; done=0; internal sum, max and counters cleared. This applies at any time, including mid-read and mid-shift. No partial result is kept.
- FSM states: IDLE, REQ, WAIT, ACC, CALC, SHIFT, DONE.
- IDLE: on avgmax_en=1, latch P_s, clear sum=0, max=0 and idx=0, then go to REQ. Otherwise hold.
- REQ: drive cs_n=0 and address=BASE_ADDR+idx (wrapping modulo 2^ADDR_W), then go to WAIT.
- WAIT: hold cs_n=0 and the address. On ry=1, capture r=read_data[RES_W-1:0] and go to ACC. There is no timeout; the block waits indefinitely for ry.
- ACC: cs_n=1. Update sum += r, with sum width RES_W+log2(NUM_WORDS) so it cannot overflow. If r > max, set max=r; ties keep the existing value. If idx==NUM_WORDS-1, go to CALC; otherwise idx++ and go to REQ.
- Per-word cost: 3 cycles minimum (REQ, WAIT with ry=1, ACC).
- CALC: max_val=max; avg_val=sum>>log2(NUM_WORDS), truncating. Load the shift register with max_val if the latched P_s=0, else avg_val. Set bit counter=RES_W-1, then go to SHIFT.
- SHIFT: one bit per cycle, MSB first, P_valid=1. This lasts exactly RES_W cycles, after which the block goes to DONE.
- DONE: done=1 for exactly one cycle, P_valid=0, P_out=0, then return to IDLE.
- max_val and avg_val hold their values until the next CALC or reset.
- avgmax_en while busy is ignored. P_s changes after start have no effect.
- Total latency from start to done, with ry immediate: 1 + 3*NUM_WORDS + 1 + RES_W cycles, plus the DONE cycle.
- we_n is constant 1: this block never writes.

Test Plan:
1. Reset mid-SHIFT: assert rst low during SHIFT -> all outputs return to reset values immediately; after release the block stays in IDLE until the next avgmax_en.
2. Ramp data, P_s=0: SRAM at 0..15 holds the values 1..16, ry answers immediately -> max_val=16, avg_val=8 (sum 136>>4). The P_out stream over 17 P_valid cycles is 0_0000_0000_0001_0000, and done pulses at cycle 67 after start.
3. Full-scale data, P_s=1: all 16 words hold 0x1FFFF with nonzero upper bits in read_data[31:17] -> upper bits are ignored, sum=0x1FFFF0 with no overflow, avg_val=0x1FFFF, and all 17 serial bits are 1.
4. Slow SRAM: ry delayed 5 cycles on each read -> cs_n and address are held stable throughout WAIT, the results are unchanged from scenario 2, and total latency grows by 80 cycles.
5. Start while busy and P_s toggle: pulse avgmax_en and flip P_s during the read phase -> there is no restart, the serialized value follows the P_s latched at start, and exactly one done pulse occurs.
6. Ties and address wrap: BASE_ADDR=250 with NUM_WORDS=16 -> addresses run 250..255 then 0..9. Data all 7 except max 9 appearing twice -> max_val=9.
